// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port data memory between the core load/store unit and the
// debug read port. One access is granted per cycle (combinationally), the loser
// stalls, and the one-cycle-latency read data is routed back to whichever
// requester issued the read. A starve counter forces a debug grant after
// MAX_WAIT consecutive denied debug cycles so debug cannot be locked out.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   core_req_i/we_i/addr_i/      core request, store enable, address,
//   core_wdata_i/be_i            store data, byte enables
//   core_gnt_o                   core accepted this cycle (low = stall)
//   core_rvalid_o/rdata_o        core read response (one cycle after grant)
//   dbg_req_i/addr_i             debug read request and address
//   dbg_gnt_o                    debug accepted this cycle
//   dbg_rvalid_o/rdata_o         debug read response (one cycle after grant)
//   mem_req_o/we_o/addr_o/       memory access strobe and command
//   mem_wdata_o/be_o
//   mem_rdata_i                  memory read data, valid cycle after a read
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [XLEN-1:0]   core_addr_i,
   input  logic [XLEN-1:0]   core_wdata_i,
   input  logic [XLEN/8-1:0] core_be_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [XLEN-1:0]   core_rdata_o,
   input  logic              dbg_req_i,
   input  logic [XLEN-1:0]   dbg_addr_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [XLEN-1:0]   dbg_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [XLEN/8-1:0] mem_be_o,
   input  logic [XLEN-1:0]   mem_rdata_i
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CORE_RD = 2'd1,
      DBG_RD  = 2'd2
   } owner_t;

   owner_t        state_reg, state_next;
   logic [CW-1:0] starve_reg, starve_next;
   logic          core_gnt, dbg_gnt;

   // Debug wins when the core is idle, or when it has been denied long enough.
   // The forced win still requires a live debug request: a saturated counter
   // left over from a withdrawn request must not steal the core's slot.
   assign dbg_gnt    = dbg_req_i & (~core_req_i | (starve_reg == STARVE_MAX));
   assign core_gnt   = core_req_i & ~dbg_gnt;
   assign core_gnt_o = core_gnt;
   assign dbg_gnt_o  = dbg_gnt;
   assign mem_req_o  = core_gnt | dbg_gnt;

   // Byte enables: core lanes on a core grant, all lanes on a debug grant.
   genvar gi;
   generate
      for (gi = 0; gi < XLEN/8; gi++) begin : g_be
         assign mem_be_o[gi] = core_gnt ? core_be_i[gi] : dbg_gnt;
      end
   endgenerate

   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (core_gnt) begin
         mem_we_o    = core_we_i;
         mem_addr_o  = core_addr_i;
         mem_wdata_o = core_wdata_i;
      end else if (dbg_gnt) begin
         mem_addr_o  = dbg_addr_i;
      end
   end

   // Starve counter: counts denied debug cycles, saturates, clears on grant
   // or when debug withdraws its request.
   always_comb begin
      starve_next = starve_reg;
      if (!dbg_req_i || dbg_gnt) begin
         starve_next = '0;
      end else if (starve_reg != STARVE_MAX) begin
         starve_next = starve_reg + CW'(1);
      end
   end

   // Read-owner tracking: remembers who owns next cycle's mem_rdata_i.
   always_comb begin
      state_next = IDLE;
      if (core_gnt && !core_we_i) begin
         state_next = CORE_RD;
      end else if (dbg_gnt) begin
         state_next = DBG_RD;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         starve_reg <= '0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
      end
   end

   // Non-owner sees zero so data is never cross-routed.
   assign core_rvalid_o = (state_reg == CORE_RD);
   assign dbg_rvalid_o  = (state_reg == DBG_RD);
   assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
   assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   localparam int XLEN     = 32;
   localparam int MAX_WAIT = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              core_req_i;
   logic              core_we_i;
   logic [XLEN-1:0]   core_addr_i;
   logic [XLEN-1:0]   core_wdata_i;
   logic [XLEN/8-1:0] core_be_i;
   logic              core_gnt_o;
   logic              core_rvalid_o;
   logic [XLEN-1:0]   core_rdata_o;
   logic              dbg_req_i;
   logic [XLEN-1:0]   dbg_addr_i;
   logic              dbg_gnt_o;
   logic              dbg_rvalid_o;
   logic [XLEN-1:0]   dbg_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [XLEN-1:0]   mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic [XLEN/8-1:0] mem_be_o;
   logic [XLEN-1:0]   mem_rdata_i;

   dmem_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_addr_i  (core_addr_i),
      .core_wdata_i (core_wdata_i),
      .core_be_i    (core_be_i),
      .core_gnt_o   (core_gnt_o),
      .core_rvalid_o(core_rvalid_o),
      .core_rdata_o (core_rdata_o),
      .dbg_req_i    (dbg_req_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_gnt_o    (dbg_gnt_o),
      .dbg_rvalid_o (dbg_rvalid_o),
      .dbg_rdata_o  (dbg_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        core_v;
      logic        dbg_v;
      logic [31:0] core_d;
      logic [31:0] dbg_d;
   } resp_t;

   resp_t       exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          m_starve = 0;
   logic        pend_rd  = 1'b0;
   logic [31:0] pend_data = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Memory content model: address-derived pattern, one fixed word for the
   // directed read at 0x10.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic resp_t idle_resp();
      resp_t r;
      r.core_v = 1'b0; r.dbg_v = 1'b0; r.core_d = '0; r.dbg_d = '0;
      return r;
   endfunction

   // One clock cycle: entered and left just after a falling edge.
   task automatic do_cycle(input logic creq, input logic cwe, input logic [31:0] caddr,
                           input logic [31:0] cwd, input logic [3:0] cbe,
                           input logic dreq, input logic [31:0] daddr);
      resp_t       e, nxt;
      logic        eg_d, eg_c, e_we;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_be;
      mem_rdata_i  = pend_rd ? pend_data : (32'hC0DE_0000 | 32'(cyc));
      core_req_i   = creq;  core_we_i = cwe;  core_addr_i = caddr;
      core_wdata_i = cwd;   core_be_i = cbe;
      dbg_req_i    = dreq;  dbg_addr_i = daddr;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_resp();
      check_val("core_rvalid", 32'(core_rvalid_o), 32'(e.core_v));
      check_val("dbg_rvalid",  32'(dbg_rvalid_o),  32'(e.dbg_v));
      check_val("core_rdata",  core_rdata_o, e.core_d);
      check_val("dbg_rdata",   dbg_rdata_o,  e.dbg_d);

      eg_d = dreq && (!creq || m_starve == MAX_WAIT);
      eg_c = creq && !eg_d;
      e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
      if (eg_c) begin
         e_we = cwe; e_addr = caddr; e_wd = cwd; e_be = cbe;
      end else if (eg_d) begin
         e_addr = daddr; e_be = 4'hF;
      end
      check_val("core_gnt",  32'(core_gnt_o), 32'(eg_c));
      check_val("dbg_gnt",   32'(dbg_gnt_o),  32'(eg_d));
      check_val("mem_req",   32'(mem_req_o),  32'(eg_c | eg_d));
      check_val("mem_we",    32'(mem_we_o),   32'(e_we));
      check_val("mem_addr",  mem_addr_o,      e_addr);
      check_val("mem_wdata", mem_wdata_o,     e_wd);
      check_val("mem_be",    32'(mem_be_o),   32'(e_be));

      $display("cyc %0d: core_req=%b we=%b dbg_req=%b -> core_gnt=%b dbg_gnt=%b rv(c/d)=%b/%b",
               cyc, creq, cwe, dreq, core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o);

      if (!dreq || eg_d) m_starve = 0;
      else if (m_starve < MAX_WAIT) m_starve++;

      nxt = idle_resp();
      pend_rd = 1'b0;
      if (eg_c && !cwe) begin
         pend_rd = 1'b1; pend_data = mem_fn(caddr);
         nxt.core_v = 1'b1; nxt.core_d = pend_data;
      end else if (eg_d) begin
         pend_rd = 1'b1; pend_data = mem_fn(daddr);
         nxt.dbg_v = 1'b1; nxt.dbg_d = pend_data;
      end
      exp_q.push_back(nxt);
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic idle_cycle();
      do_cycle(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(idle_resp());
      m_starve = 0;
      pend_rd  = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      core_req_i = 0; core_we_i = 0; core_addr_i = '0; core_wdata_i = '0; core_be_i = '0;
      dbg_req_i = 0; dbg_addr_i = '0; mem_rdata_i = 32'h1234_5678;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      check_val("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
      check_val("rst_dbg_rvalid",  32'(dbg_rvalid_o),  32'd0);
      check_val("rst_core_rdata",  core_rdata_o, 32'd0);
      check_val("rst_dbg_rdata",   dbg_rdata_o,  32'd0);
      check_val("rst_mem_req",     32'(mem_req_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();

      // Core read at 0x10, then store at 0x20, then idle (no response).
      do_cycle(1'b1, 1'b0, 32'h10, '0, 4'hF, 1'b0, '0);
      do_cycle(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, '0);
      idle_cycle();
      // Debug read at 0x40 with core idle.
      do_cycle(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 32'h40);
      idle_cycle();

      // Continuous contention: core x4 then debug, repeating.
      for (int i = 0; i < 12; i++)
         do_cycle(1'b1, 1'b0, 32'h100 + 32'(i*4), '0, 4'hF, 1'b1, 32'h200 + 32'(i*4));
      // Contention with core stores, including a debug withdrawal mid-wait.
      for (int i = 0; i < 8; i++)
         do_cycle(1'b1, 1'b1, 32'h300 + 32'(i*4), 32'hA500_0000 + 32'(i), 4'h3,
                  (i != 2), 32'h400);

      // Alternating core read / debug read, back to back.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) do_cycle(1'b1, 1'b0, 32'h500 + 32'(i*4), '0, 4'hF, 1'b0, '0);
         else            do_cycle(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 32'h600 + 32'(i*4));
      end

      // Random traffic.
      for (int i = 0; i < 40; i++)
         do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFC,
                  $urandom, 4'($urandom), 1'($urandom_range(0, 1)), $urandom & 32'hFFC);

      // Build up starvation, then reset right after a granted core read.
      for (int i = 0; i < 3; i++)
         do_cycle(1'b1, 1'b0, 32'h700 + 32'(i*4), '0, 4'hF, 1'b1, 32'h800);
      core_req_i = 1'b0; dbg_req_i = 1'b0;
      rst_i = 1'b1;
      #1;
      check_val("midrst_core_rvalid", 32'(core_rvalid_o), 32'd0);
      check_val("midrst_core_rdata",  core_rdata_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      idle_cycle();
      // Counter must restart from 0: debug granted only on the 5th cycle.
      for (int i = 0; i < 6; i++)
         do_cycle(1'b1, 1'b0, 32'h900 + 32'(i*4), '0, 4'hF, 1'b1, 32'hA00);
      idle_cycle();
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
